// File: rtl/mrv1_itag_alloc.sv
`default_nettype none
// ============================================================================
// Module   : mrv1_itag_alloc
// Purpose  : Per-thread instruction-tag (ITAG) allocator and in-flight tracker.
//            Each hardware thread owns a circular queue of 2^ITAG_WIDTH_P slots.
//            Dispatch takes ITAGs in program order from the tail. Each slot
//            records the instruction's destination-register information. The
//            retire stage sees the head (oldest outstanding ITAG) and the
//            per-slot rd arrays, and frees entries by reporting a count.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i            clock
//   rst_ni           asynchronous active-low reset
//   alloc_vld_i      dispatch requests an ITAG for thread alloc_tid_i
//   alloc_tid_i      requesting thread
//   alloc_rd_vld_i   instruction writes a destination register
//   alloc_rd_addr_i  destination register address
//   alloc_rdy_o      per-thread "slot available" (low when full or flushing)
//   alloc_itag_o     ITAG granted to alloc_tid_i (that thread's tail)
//   retire_en_i      per-thread retire strobe
//   retire_cnt_i     per-thread number of entries to retire
//   flush_i          per-thread flush
//   retire_itag_o    per-thread oldest outstanding ITAG (head)
//   iq_rd_vld_o      per-thread, per-slot rd-valid
//   iq_rd_addr_o     per-thread, per-slot rd address
//   empty_o          per-thread "no outstanding ITAGs"
//   stall_cnt_o      per-thread blocked-allocation counters
// ----------------------------------------------------------------------------
// Build option
//   MRV1_ITAG_STALL_CNT_EN : when defined, each thread has a saturating 16-bit
//                            counter of cycles in which an allocation request
//                            for it was refused. Only reset clears the
//                            counter; flush does not. When undefined,
//                            stall_cnt_o is tied to zero and no counter flops
//                            exist.
// ============================================================================
module mrv1_itag_alloc #(
    parameter  int NUM_TW_P        = 8,
    parameter  int ITAG_WIDTH_P    = 4,
    parameter  int rf_addr_width_p = 5,
    localparam int tid_width_lp    = (NUM_TW_P > 1) ? $clog2(NUM_TW_P) : 1,
    localparam int iqueue_size_lp  = 1 << ITAG_WIDTH_P
) (
    input  logic                                                           clk_i,
    input  logic                                                           rst_ni,
    // dispatch side
    input  logic                                                           alloc_vld_i,
    input  logic [tid_width_lp-1:0]                                        alloc_tid_i,
    input  logic                                                           alloc_rd_vld_i,
    input  logic [rf_addr_width_p-1:0]                                     alloc_rd_addr_i,
    output logic [NUM_TW_P-1:0]                                            alloc_rdy_o,
    output logic [ITAG_WIDTH_P-1:0]                                        alloc_itag_o,
    // retire side
    input  logic [NUM_TW_P-1:0]                                            retire_en_i,
    input  logic [NUM_TW_P-1:0][ITAG_WIDTH_P-1:0]                          retire_cnt_i,
    input  logic [NUM_TW_P-1:0]                                            flush_i,
    output logic [NUM_TW_P-1:0][ITAG_WIDTH_P-1:0]                          retire_itag_o,
    output logic [NUM_TW_P-1:0][iqueue_size_lp-1:0]                        iq_rd_vld_o,
    output logic [NUM_TW_P-1:0][iqueue_size_lp-1:0][rf_addr_width_p-1:0]   iq_rd_addr_o,
    output logic [NUM_TW_P-1:0]                                            empty_o,
    output logic [NUM_TW_P-1:0][15:0]                                      stall_cnt_o
);

    // Occupancy value meaning "full": one slot is always kept empty so that
    // occupancy and the largest legal retire count fit in ITAG_WIDTH_P bits.
    localparam logic [ITAG_WIDTH_P-1:0] c_occ_full = '1;

    // Tail pointers of all threads, muxed onto alloc_itag_o by alloc_tid_i.
    logic [NUM_TW_P-1:0][ITAG_WIDTH_P-1:0] w_tail;

    assign alloc_itag_o = w_tail[alloc_tid_i];

    for (genvar t = 0; t < NUM_TW_P; t++) begin : g_thread

        logic [ITAG_WIDTH_P-1:0]                       head_q, head_d;
        logic [ITAG_WIDTH_P-1:0]                       tail_q, tail_d;
        logic [ITAG_WIDTH_P-1:0]                       occ_q,  occ_d;
        logic [iqueue_size_lp-1:0]                     rd_vld_q, rd_vld_d;
        logic [iqueue_size_lp-1:0][rf_addr_width_p-1:0] rd_addr_q, rd_addr_d;

        logic                                          w_alloc_hit;
        logic                                          w_alloc_acc;
        logic [ITAG_WIDTH_P-1:0]                       w_ret_n;
        logic [iqueue_size_lp-1:0][ITAG_WIDTH_P-1:0]   w_off;
        logic [iqueue_size_lp-1:0]                     w_clr;

        assign alloc_rdy_o[t] = (occ_q != c_occ_full) & ~flush_i[t];
        assign w_alloc_hit    = alloc_vld_i & (alloc_tid_i == tid_width_lp'(t));
        assign w_alloc_acc    = w_alloc_hit & alloc_rdy_o[t];

        // An over-large retire count is clamped to the occupancy so that a
        // misbehaving retire stage can never drive head past tail.
        assign w_ret_n = ~retire_en_i[t]          ? '0    :
                         (retire_cnt_i[t] > occ_q) ? occ_q :
                                                     retire_cnt_i[t];

        // A slot is being retired when its distance from head (mod ring size)
        // is below the retire count. The slot an allocation writes sits at
        // distance occ >= n, so the clear and the write never overlap.
        for (genvar s = 0; s < iqueue_size_lp; s++) begin : g_slot
            assign w_off[s] = ITAG_WIDTH_P'(s) - head_q;
            assign w_clr[s] = (w_off[s] < w_ret_n);
        end

        always_comb begin
            head_d    = head_q;
            tail_d    = tail_q;
            occ_d     = occ_q;
            rd_vld_d  = rd_vld_q;
            rd_addr_d = rd_addr_q;
            if (flush_i[t]) begin
                // Flush discards every outstanding entry; head stays put so
                // the next ITAG handed out continues from the oldest point.
                tail_d   = head_q;
                occ_d    = '0;
                rd_vld_d = '0;
            end else begin
                rd_vld_d = rd_vld_q & ~w_clr;
                if (w_alloc_acc) begin
                    rd_vld_d[tail_q]  = alloc_rd_vld_i;
                    rd_addr_d[tail_q] = alloc_rd_addr_i;
                    tail_d            = tail_q + 1'b1;
                end
                head_d = head_q + w_ret_n;
                occ_d  = occ_q + {{(ITAG_WIDTH_P-1){1'b0}}, w_alloc_acc} - w_ret_n;
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                head_q    <= '0;
                tail_q    <= '0;
                occ_q     <= '0;
                rd_vld_q  <= '0;
                rd_addr_q <= '0;
            end else begin
                head_q    <= head_d;
                tail_q    <= tail_d;
                occ_q     <= occ_d;
                rd_vld_q  <= rd_vld_d;
                rd_addr_q <= rd_addr_d;
            end
        end

        assign w_tail[t]        = tail_q;
        assign retire_itag_o[t] = head_q;
        assign iq_rd_vld_o[t]   = rd_vld_q;
        assign iq_rd_addr_o[t]  = rd_addr_q;
        assign empty_o[t]       = (occ_q == '0);

`ifdef MRV1_ITAG_STALL_CNT_EN
        // Counts refused requests, whether refused for lack of space or
        // because the thread is flushing; sticks at all-ones.
        logic [15:0] stall_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                stall_q <= '0;
            end else if (w_alloc_hit && !alloc_rdy_o[t] && (stall_q != 16'hFFFF)) begin
                stall_q <= stall_q + 16'd1;
            end
        end

        assign stall_cnt_o[t] = stall_q;
`else
        assign stall_cnt_o[t] = 16'h0000;
`endif

    end

endmodule
`default_nettype wire

// File: tb/tb_mrv1_itag_alloc.sv
`default_nettype none
// ============================================================================
// Module   : tb_mrv1_itag_alloc
// Purpose  : Scoreboard bench for mrv1_itag_alloc. Stimulus pushes expected
//            ITAG grants and expected output observations into queues; a
//            monitor pops and compares them on the falling clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mrv1_itag_alloc;

`ifdef MRV1_ITAG_STALL_CNT_EN
    localparam logic [31:0] c_stall_one = 32'd1;
`else
    localparam logic [31:0] c_stall_one = 32'd0;
`endif

    localparam int K_RDY   = 0;
    localparam int K_EMPTY = 1;
    localparam int K_ITAG  = 2;
    localparam int K_RET   = 3;
    localparam int K_VLD   = 4;
    localparam int K_ADDR  = 5;
    localparam int K_STALL = 6;

    logic                 clk;
    logic                 rst_ni;
    logic                 alloc_vld_i;
    logic [2:0]           alloc_tid_i;
    logic                 alloc_rd_vld_i;
    logic [4:0]           alloc_rd_addr_i;
    logic [7:0]           alloc_rdy_o;
    logic [3:0]           alloc_itag_o;
    logic [7:0]           retire_en_i;
    logic [7:0][3:0]      retire_cnt_i;
    logic [7:0]           flush_i;
    logic [7:0][3:0]      retire_itag_o;
    logic [7:0][15:0]     iq_rd_vld_o;
    logic [7:0][15:0][4:0] iq_rd_addr_o;
    logic [7:0]           empty_o;
    logic [7:0][15:0]     stall_cnt_o;

    mrv1_itag_alloc dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .alloc_vld_i     (alloc_vld_i),
        .alloc_tid_i     (alloc_tid_i),
        .alloc_rd_vld_i  (alloc_rd_vld_i),
        .alloc_rd_addr_i (alloc_rd_addr_i),
        .alloc_rdy_o     (alloc_rdy_o),
        .alloc_itag_o    (alloc_itag_o),
        .retire_en_i     (retire_en_i),
        .retire_cnt_i    (retire_cnt_i),
        .flush_i         (flush_i),
        .retire_itag_o   (retire_itag_o),
        .iq_rd_vld_o     (iq_rd_vld_o),
        .iq_rd_addr_o    (iq_rd_addr_o),
        .empty_o         (empty_o),
        .stall_cnt_o     (stall_cnt_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          cyc;
        int          kind;
        int          t;
        int          idx;
        logic [31:0] exp;
        string       name;
    } chk_t;

    chk_t       chk_q[$];
    logic [3:0] itag_q[$];
    int         cyc       = 0;
    bit         stim_done = 1'b0;
    int         n_tests   = 0;
    int         n_fail    = 0;

    always @(posedge clk) cyc++;

    function automatic logic [31:0] observe(input int kind, input int t, input int idx);
        case (kind)
            K_RDY:   return 32'(alloc_rdy_o);
            K_EMPTY: return 32'(empty_o);
            K_ITAG:  return 32'(alloc_itag_o);
            K_RET:   return 32'(retire_itag_o[t]);
            K_VLD:   return 32'(iq_rd_vld_o[t]);
            K_ADDR:  return 32'(iq_rd_addr_o[t][idx]);
            default: return 32'(stall_cnt_o[t]);
        endcase
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        chk_t        c;
        logic [31:0] obs;
        logic [3:0]  ei;
        while (chk_q.size() > 0 && chk_q[0].cyc <= cyc) begin
            c   = chk_q.pop_front();
            obs = observe(c.kind, c.t, c.idx);
            n_tests++;
            if (c.cyc != cyc || obs !== c.exp) begin
                n_fail++;
                $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", c.name, obs, c.exp, cyc);
            end
        end
        if (rst_ni && alloc_vld_i && alloc_rdy_o[alloc_tid_i]) begin
            n_tests++;
            if (itag_q.size() == 0) begin
                n_fail++;
                $display("FAIL grant: unexpected grant to thread %0d itag %0d (none expected)",
                         alloc_tid_i, alloc_itag_o);
            end else begin
                ei = itag_q.pop_front();
                if (alloc_itag_o !== ei) begin
                    n_fail++;
                    $display("FAIL grant_itag: thread %0d got %0d expected %0d",
                             alloc_tid_i, alloc_itag_o, ei);
                end
            end
        end
        if (stim_done || cyc > 5000) begin
            n_tests++;
            if (cyc > 5000) begin
                n_fail++;
                $display("FAIL timeout: cycle %0d exceeded budget 5000", cyc);
            end else if (chk_q.size() != 0 || itag_q.size() != 0) begin
                n_fail++;
                $display("FAIL leftover: %0d checks and %0d grants still pending, expected 0",
                         chk_q.size(), itag_q.size());
            end
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        alloc_vld_i     = 1'b0;
        alloc_tid_i     = 3'd0;
        alloc_rd_vld_i  = 1'b0;
        alloc_rd_addr_i = 5'd0;
        retire_en_i     = '0;
        retire_cnt_i    = '0;
        flush_i         = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic chk(input string name, input int kind, input int t, input int idx,
                       input logic [31:0] exp);
        chk_t c;
        c.cyc  = cyc;
        c.kind = kind;
        c.t    = t;
        c.idx  = idx;
        c.exp  = exp;
        c.name = name;
        chk_q.push_back(c);
    endtask

    // exp_itag < 0 means the request must be refused
    task automatic do_alloc(input int tid, input bit rdv, input int addr, input int exp_itag);
        alloc_vld_i     = 1'b1;
        alloc_tid_i     = 3'(tid);
        alloc_rd_vld_i  = rdv;
        alloc_rd_addr_i = 5'(addr);
        if (exp_itag >= 0) itag_q.push_back(4'(exp_itag));
        step();
    endtask

    task automatic do_retire(input int tid, input int n);
        retire_en_i[tid]  = 1'b1;
        retire_cnt_i[tid] = 4'(n);
        step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        idle();
        rst_ni = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_ni = 1'b1;

        // reset state
        chk("rst_rdy",   K_RDY,   0, 0, 32'hFF);
        chk("rst_empty", K_EMPTY, 0, 0, 32'hFF);
        chk("rst_itag",  K_ITAG,  0, 0, 32'h0);
        chk("rst_ret0",  K_RET,   0, 0, 32'h0);
        chk("rst_vld0",  K_VLD,   0, 0, 32'h0);
        chk("rst_stall", K_STALL, 0, 0, 32'h0);
        step();

        // thread 2: rd x5, no rd, rd x7
        do_alloc(2, 1'b1, 5, 0);
        do_alloc(2, 1'b0, 0, 1);
        do_alloc(2, 1'b1, 7, 2);
        chk("t2_vld",   K_VLD,   2, 0, 32'h0005);
        chk("t2_addr2", K_ADDR,  2, 2, 32'd7);
        chk("t2_addr0", K_ADDR,  2, 0, 32'd5);
        chk("t2_empty", K_EMPTY, 0, 0, 32'hFB);
        chk("t2_head",  K_RET,   2, 0, 32'd0);
        step();

        // thread 0: fill to capacity (15), then a refused request
        for (int i = 0; i < 15; i++) do_alloc(0, 1'b1, i, i);
        chk("t0_full_rdy", K_RDY,   0, 0, 32'hFE);
        chk("t0_full_vld", K_VLD,   0, 0, 32'h7FFF);
        chk("t0_empty",    K_EMPTY, 0, 0, 32'hFA);
        step();
        chk("t0_blk_itag",  K_ITAG,  0, 0, 32'd15);
        chk("t0_blk_stall", K_STALL, 0, 0, 32'd0);
        do_alloc(0, 1'b1, 31, -1);
        chk("t0_drop_rdy",   K_RDY,   0, 0, 32'hFE);
        chk("t0_drop_vld",   K_VLD,   0, 0, 32'h7FFF);
        chk("t0_drop_stall", K_STALL, 0, 0, c_stall_one);
        alloc_tid_i = 3'd0;
        chk("t0_drop_tail",  K_ITAG,  0, 0, 32'd15);
        step();

        // thread 1: move head to 14, occupy 14,15,0,1, retire 3 across the wrap
        for (int i = 0; i < 14; i++) do_alloc(1, 1'b1, 1, i);
        chk("t1_pre_head", K_RET, 1, 0, 32'd0);
        do_retire(1, 14);
        chk("t1_head14",  K_RET,   1, 0, 32'd14);
        chk("t1_empty",   K_EMPTY, 0, 0, 32'hFA);
        chk("t1_vld_clr", K_VLD,   1, 0, 32'h0);
        for (int i = 0; i < 4; i++) do_alloc(1, 1'b1, 20 + i, (14 + i) % 16);
        chk("t1_wrap_vld", K_VLD, 1, 0, 32'hC003);
        chk("t1_wrap_hd",  K_RET, 1, 0, 32'd14);
        do_retire(1, 3);
        chk("t1_ret3_head", K_RET, 1, 0, 32'd1);
        chk("t1_ret3_vld",  K_VLD, 1, 0, 32'h0002);
        alloc_tid_i = 3'd1;
        chk("t1_ret3_tail", K_ITAG, 0, 0, 32'd2);
        // occupancy is 1: a count of 5 must clamp to 1
        do_retire(1, 5);
        chk("t1_clamp_head",  K_RET,   1, 0, 32'd2);
        chk("t1_clamp_vld",   K_VLD,   1, 0, 32'h0);
        chk("t1_clamp_empty", K_EMPTY, 0, 0, 32'hFA);
        alloc_tid_i = 3'd1;
        chk("t1_clamp_tail",  K_ITAG,  0, 0, 32'd2);
        step();

        // thread 3: full, then same-cycle allocation and retire of 1
        for (int i = 0; i < 15; i++) do_alloc(3, 1'b1, 2, i);
        chk("t3_same_rdy", K_RDY, 0, 0, 32'hF6);
        retire_en_i[3]  = 1'b1;
        retire_cnt_i[3] = 4'd1;
        do_alloc(3, 1'b1, 9, -1);
        chk("t3_after_rdy",   K_RDY,   0, 0, 32'hFE);
        chk("t3_after_head",  K_RET,   3, 0, 32'd1);
        chk("t3_after_vld",   K_VLD,   3, 0, 32'h7FFE);
        chk("t3_after_stall", K_STALL, 3, 0, c_stall_one);
        alloc_tid_i = 3'd3;
        chk("t3_after_tail",  K_ITAG,  0, 0, 32'd15);
        step();

        // thread 5 bystander, thread 4 flushed with a same-cycle allocation
        do_alloc(5, 1'b1, 9, 0);
        do_alloc(5, 1'b1, 10, 1);
        for (int i = 0; i < 5; i++) do_alloc(4, 1'b1, 3, i);
        do_retire(4, 2);
        flush_i[4] = 1'b1;
        chk("t4_flush_rdy",  K_RDY,  0, 0, 32'hEE);
        chk("t4_flush_tail", K_ITAG, 0, 0, 32'd5);
        do_alloc(4, 1'b1, 3, -1);
        chk("t4_empty",   K_EMPTY, 0, 0, 32'hD2);
        chk("t4_vld",     K_VLD,   4, 0, 32'h0);
        chk("t4_head",    K_RET,   4, 0, 32'd2);
        chk("t4_rdy",     K_RDY,   0, 0, 32'hFE);
        chk("t5_vld",     K_VLD,   5, 0, 32'h0003);
        chk("t5_addr1",   K_ADDR,  5, 1, 32'd10);
        chk("t5_addr0",   K_ADDR,  5, 0, 32'd9);
        do_alloc(4, 1'b0, 0, 2);

        // asynchronous reset in the middle of a pending allocation
        alloc_vld_i     = 1'b1;
        alloc_tid_i     = 3'd2;
        alloc_rd_vld_i  = 1'b1;
        alloc_rd_addr_i = 5'd6;
        #2;
        rst_ni = 1'b0;
        chk("arst_rdy",   K_RDY,   0, 0, 32'hFF);
        chk("arst_empty", K_EMPTY, 0, 0, 32'hFF);
        chk("arst_itag",  K_ITAG,  0, 0, 32'd0);
        chk("arst_ret1",  K_RET,   1, 0, 32'd0);
        chk("arst_ret4",  K_RET,   4, 0, 32'd0);
        chk("arst_vld2",  K_VLD,   2, 0, 32'h0);
        chk("arst_addr",  K_ADDR,  2, 2, 32'd0);
        chk("arst_stall", K_STALL, 0, 0, 32'd0);
        step();
        rst_ni = 1'b1;
        do_alloc(2, 1'b0, 0, 0);
        chk("post_rst_empty", K_EMPTY, 0, 0, 32'hFB);
        chk("post_rst_vld",   K_VLD,   2, 0, 32'h0);
        step();

        stim_done = 1'b1;
    end

endmodule
`default_nettype wire
